// File: rtl/encode_tx_66b.sv
// 64b/66b transmit encoder for a 10GBASE-R PCS lane.
// Stage 1 classifies the XGMII word and prebuilds its 66-bit block; stage 2
// runs the transmit state machine, substitutes error blocks and counts them.
module encode_tx_66b #(
  parameter logic [7:0] IDLE_CHAR = 8'h07,
  parameter logic [7:0] ERR_CHAR  = 8'hFE
) (
  input  logic        clk156,
  input  logic        rstb156,
  input  logic [63:0] txdata,
  input  logic [7:0]  txcontrol,
  input  logic        tx_en,
  input  logic        bypass_66encoder,
  input  logic        clear_errblk,
  output logic [65:0] TXD_Encoded,
  output logic [2:0]  tx_state,
  output logic [7:0]  errd_blks
);

  localparam logic [7:0]  START_CHAR = 8'hFB;
  localparam logic [7:0]  TERM_CHAR  = 8'hFD;
  localparam logic [7:0]  SEQ_CHAR   = 8'h9C;
  localparam logic [1:0]  HDR_DATA   = 2'b10;
  localparam logic [1:0]  HDR_CTRL   = 2'b01;
  localparam logic [6:0]  CODE_IDLE  = 7'h00;
  localparam logic [6:0]  CODE_ERR   = 7'h1E;
  localparam logic [7:0]  TYPE_CTRL  = 8'h1E;
  localparam logic [7:0]  TYPE_OS    = 8'h4B;
  localparam logic [7:0]  TYPE_S0    = 8'h78;
  localparam logic [7:0]  TYPE_S4    = 8'h33;
  localparam logic [65:0] IDLE_BLOCK = {56'h0, TYPE_CTRL, HDR_CTRL};
  localparam logic [65:0] EBLOCK_T   = {{8{CODE_ERR}}, TYPE_CTRL, HDR_CTRL};

  typedef enum logic [2:0] {
    TX_INIT = 3'd0,
    TX_C    = 3'd1,
    TX_D    = 3'd2,
    TX_T    = 3'd3,
    TX_E    = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    BLK_C,
    BLK_S,
    BLK_D,
    BLK_T,
    BLK_E
  } blk_class_t;

  // Block type for a terminate character in lane k.
  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    return 8'h87;
      3'd1:    return 8'h99;
      3'd2:    return 8'hAA;
      3'd3:    return 8'hB4;
      3'd4:    return 8'hCC;
      3'd5:    return 8'hD2;
      3'd6:    return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  logic [55:0] ctrl_codes;
  logic        ctrl_ok;
  logic [7:0]  term_hit;
  blk_class_t  cls_type;
  logic [65:0] cls_block;

  blk_class_t  s1_type;
  logic [65:0] s1_block;
  logic        s1_bypass;
  logic        s1_valid;

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [65:0] out_nxt;
  logic        err_inc;

  // Map every lane to its 7-bit control code; flag any lane that is neither idle nor error.
  always_comb begin
    ctrl_ok    = 1'b1;
    ctrl_codes = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (txdata[8*k +: 8] == IDLE_CHAR)
        ctrl_codes[7*k +: 7] = CODE_IDLE;
      else if (txdata[8*k +: 8] == ERR_CHAR)
        ctrl_codes[7*k +: 7] = CODE_ERR;
      else
        ctrl_ok = 1'b0;
    end
  end

  // Detect a terminate in lane k: control bits k..7 set, lanes above k idle.
  always_comb begin
    term_hit = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      term_hit[k] = (txdata[8*k +: 8] == TERM_CHAR) && (txcontrol == (8'hFF << k));
      for (int unsigned j = k + 1; j < 8; j++) begin
        if (txdata[8*j +: 8] != IDLE_CHAR)
          term_hit[k] = 1'b0;
      end
    end
  end

  // Classify the incoming word and build the corresponding 66-bit block.
  always_comb begin
    cls_type  = BLK_E;
    cls_block = EBLOCK_T;
    if (txcontrol == 8'h00) begin
      cls_type  = BLK_D;
      cls_block = {txdata, HDR_DATA};
    end else if (txcontrol == 8'hFF && ctrl_ok) begin
      cls_type  = BLK_C;
      cls_block = {ctrl_codes, TYPE_CTRL, HDR_CTRL};
    end else if (txcontrol == 8'h01 && txdata[7:0] == SEQ_CHAR) begin
      cls_type  = BLK_C;
      cls_block = {32'h0, txdata[31:8], TYPE_OS, HDR_CTRL};
    end else if (txcontrol == 8'h01 && txdata[7:0] == START_CHAR) begin
      cls_type  = BLK_S;
      cls_block = {txdata[63:8], TYPE_S0, HDR_CTRL};
    end else if (txcontrol == 8'h1F && txdata[31:0] == {4{IDLE_CHAR}} &&
                 txdata[39:32] == START_CHAR) begin
      cls_type  = BLK_S;
      cls_block = {txdata[63:40], 32'h0, TYPE_S4, HDR_CTRL};
    end else if (|term_hit) begin
      cls_type  = BLK_T;
      cls_block = '0;
      cls_block[1:0] = HDR_CTRL;
      for (int unsigned k = 0; k < 8; k++) begin
        if (term_hit[k]) begin
          cls_block[9:2] = term_type(3'(k));
          for (int unsigned j = 0; j < k; j++)
            cls_block[10 + 8*j +: 8] = txdata[8*j +: 8];
        end
      end
    end
  end

  // Stage 1: register classification and prebuilt block (or raw bypass block).
  always_ff @(posedge clk156 or negedge rstb156) begin
    if (!rstb156) begin
      s1_type   <= BLK_C;
      s1_block  <= IDLE_BLOCK;
      s1_bypass <= 1'b0;
      s1_valid  <= 1'b0;
    end else if (tx_en) begin
      s1_type   <= cls_type;
      s1_block  <= bypass_66encoder ? {txdata, HDR_DATA} : cls_block;
      s1_bypass <= bypass_66encoder;
      s1_valid  <= 1'b1;
    end
  end

  // Next state and output block. s1_valid keeps the FSM in TX_INIT until a
  // real word reaches stage 1, so the first word after reset is judged from INIT.
  always_comb begin
    state_nxt = state;
    out_nxt   = TXD_Encoded;
    err_inc   = 1'b0;
    if (s1_valid) begin
      if (s1_bypass) begin
        state_nxt = TX_INIT;
        out_nxt   = s1_block;
      end else begin
        unique case (state)
          TX_INIT, TX_C, TX_T: begin
            case (s1_type)
              BLK_C:   state_nxt = TX_C;
              BLK_S:   state_nxt = TX_D;
              default: state_nxt = TX_E;
            endcase
          end
          TX_D: begin
            case (s1_type)
              BLK_D:   state_nxt = TX_D;
              BLK_T:   state_nxt = TX_T;
              default: state_nxt = TX_E;
            endcase
          end
          TX_E: begin
            case (s1_type)
              BLK_C:   state_nxt = TX_C;
              BLK_D:   state_nxt = TX_D;
              BLK_T:   state_nxt = TX_T;
              default: state_nxt = TX_E;
            endcase
          end
          default: state_nxt = TX_E;
        endcase
        err_inc = (state_nxt == TX_E);
        out_nxt = err_inc ? EBLOCK_T : s1_block;
      end
    end
  end

  // Stage 2: state register and output block register.
  always_ff @(posedge clk156 or negedge rstb156) begin
    if (!rstb156) begin
      state       <= TX_INIT;
      TXD_Encoded <= IDLE_BLOCK;
    end else if (tx_en) begin
      state       <= state_nxt;
      TXD_Encoded <= out_nxt;
    end
  end

  // Saturating error-block counter; clear wins and works while stalled.
  always_ff @(posedge clk156 or negedge rstb156) begin
    if (!rstb156)
      errd_blks <= '0;
    else if (clear_errblk)
      errd_blks <= '0;
    else if (tx_en && err_inc && errd_blks != 8'hFF)
      errd_blks <= errd_blks + 8'd1;
  end

  assign tx_state = state;

endmodule

// File: tb/tb_encode_tx_66b.sv
// Bench for encode_tx_66b: fixed vector table, directed multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_encode_tx_66b;

  logic        clk156 = 1'b0;
  logic        rstb156 = 1'b0;
  logic [63:0] txdata = '0;
  logic [7:0]  txcontrol = '0;
  logic        tx_en = 1'b0;
  logic        bypass_66encoder = 1'b0;
  logic        clear_errblk = 1'b0;
  logic [65:0] TXD_Encoded;
  logic [2:0]  tx_state;
  logic [7:0]  errd_blks;

  encode_tx_66b #(.IDLE_CHAR(8'h07), .ERR_CHAR(8'hFE)) dut (
    .clk156(clk156),
    .rstb156(rstb156),
    .txdata(txdata),
    .txcontrol(txcontrol),
    .tx_en(tx_en),
    .bypass_66encoder(bypass_66encoder),
    .clear_errblk(clear_errblk),
    .TXD_Encoded(TXD_Encoded),
    .tx_state(tx_state),
    .errd_blks(errd_blks)
  );

  always #5 clk156 = ~clk156;

  localparam logic [63:0] IDLE_W   = 64'h0707070707070707;
  localparam logic [65:0] IDLE_BLK = 66'h79;
  localparam logic [65:0] EBLK     = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [63:0] S0_W     = 64'h5555_5555_5555_55FB;
  localparam logic [65:0] S0_BLK   = {56'h55555555555555, 8'h78, 2'b01};
  localparam logic [63:0] D_W      = 64'h0123456789ABCDEF;
  localparam logic [65:0] D_BLK    = {D_W, 2'b10};
  localparam logic [63:0] T0_W     = 64'h07070707070707FD;
  localparam logic [65:0] T0_BLK   = {56'h0, 8'h87, 2'b01};
  localparam logic [63:0] BYP_W    = 64'hDEADBEEF_00000000;
  localparam logic [65:0] BYP_BLK  = {BYP_W, 2'b10};
  localparam logic [63:0] E_W      = 64'h0;
  localparam logic [7:0]  E_C      = 8'h80;

  int n_cmp = 0;
  int n_bad = 0;
  string phase = "reset";

  // Model: block classes 0=C 1=S 2=D 3=T 4=E; states 0=INIT 1=C 2=D 3=T 4=E.
  int nxt [5][5] = '{
    '{1, 2, 4, 4, 4},
    '{1, 2, 4, 4, 4},
    '{4, 4, 2, 3, 4},
    '{1, 2, 4, 4, 4},
    '{1, 4, 2, 3, 4}
  };
  logic [7:0] ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        byp;
  } word_t;
  word_t hist[$];

  int          m_state = 0;
  int          m_cnt = 0;
  logic [65:0] m_out = IDLE_BLK;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic        byp;
    logic        clr;
    logic [65:0] blk;
    logic [2:0]  st;
    logic [7:0]  cnt;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h, expected %h", phase, name, act, exp);
    end
  endtask

  task automatic classify(input logic [63:0] d, input logic [7:0] c,
                          output int cls, output logic [65:0] blk);
    logic [7:0]  b [8];
    logic [55:0] codes;
    logic [63:0] mask;
    bit          all_ctrl;
    bit          tail_idle;
    int          kk;
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    cls = 4;
    blk = EBLK;
    all_ctrl = 1;
    codes = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i] == 8'hFE) codes[7*i +: 7] = 7'h1E;
      else if (b[i] != 8'h07) all_ctrl = 0;
    end
    kk = -1;
    for (int i = 7; i >= 0; i--) if (c[i]) kk = i;
    if (c == 8'h00) begin
      cls = 2; blk = {d, 2'b10};
    end else if (c == 8'hFF && all_ctrl) begin
      cls = 0; blk = {codes, 8'h1E, 2'b01};
    end else if (c == 8'h01 && b[0] == 8'h9C) begin
      cls = 0; blk = {32'h0, d[31:8], 8'h4B, 2'b01};
    end else if (c == 8'h01 && b[0] == 8'hFB) begin
      cls = 1; blk = {d[63:8], 8'h78, 2'b01};
    end else if (c == 8'h1F && b[0] == 8'h07 && b[1] == 8'h07 && b[2] == 8'h07 &&
                 b[3] == 8'h07 && b[4] == 8'hFB) begin
      cls = 1; blk = {d[63:40], 32'h0, 8'h33, 2'b01};
    end else if (kk >= 0 && b[kk] == 8'hFD && (c >> kk) == (8'hFF >> kk)) begin
      tail_idle = 1;
      for (int i = kk + 1; i < 8; i++) if (b[i] != 8'h07) tail_idle = 0;
      if (tail_idle) begin
        mask = (64'd1 << (8 * kk)) - 64'd1;
        mask = d & mask;
        cls = 3;
        blk = {mask[55:0], ttype[kk], 2'b01};
      end
    end
  endtask

  task automatic model_proc(input word_t w);
    int          cls;
    int          ns;
    logic [65:0] blk;
    if (w.byp) begin
      m_out = {w.d, 2'b10};
      m_state = 0;
    end else begin
      classify(w.d, w.c, cls, blk);
      ns = nxt[m_state][cls];
      if (ns == 4) begin
        m_out = EBLK;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_out = blk;
      end
      m_state = ns;
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_state = 0;
    m_cnt = 0;
    m_out = IDLE_BLK;
  endtask

  task automatic step(input logic [63:0] d, input logic [7:0] c, input logic en,
                      input logic byp, input logic clr, input bit use_model);
    txdata = d;
    txcontrol = c;
    tx_en = en;
    bypass_66encoder = byp;
    clear_errblk = clr;
    @(posedge clk156);
    if (en) begin
      hist.push_back('{d: d, c: c, byp: byp});
      if (hist.size() >= 2) model_proc(hist[hist.size() - 2]);
      if (hist.size() > 2) hist.delete(0);
    end
    if (clr) m_cnt = 0;
    #1;
    if (use_model) begin
      chk("blk", TXD_Encoded, m_out);
      chk("state", 66'(tx_state), 66'(m_state));
      chk("errd", 66'(errd_blks), 66'(m_cnt));
    end
  endtask

  task automatic gen_word(output logic [63:0] d, output logic [7:0] c);
    int k;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0: begin
        d = IDLE_W;
        if ($urandom_range(0, 3) == 0) d[8*$urandom_range(0, 7) +: 8] = 8'hFE;
        c = 8'hFF;
      end
      1: begin d[7:0] = 8'hFB; c = 8'h01; end
      2: begin d[39:0] = 40'hFB_07070707; c = 8'h1F; end
      3, 4: c = 8'h00;
      5: begin
        k = $urandom_range(0, 7);
        d[8*k +: 8] = 8'hFD;
        for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
        c = 8'hFF << k;
      end
      6: begin d[7:0] = 8'h9C; c = 8'h01; end
      default: c = 8'($urandom);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic [7:0]  rc;

    tbl[0]  = '{IDLE_W, 8'hFF, 1'b0, 1'b0, IDLE_BLK, 3'd0, 8'd0};
    tbl[1]  = '{IDLE_W, 8'hFF, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd0};
    tbl[2]  = '{IDLE_W, 8'hFF, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd0};
    tbl[3]  = '{S0_W,   8'h01, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd0};
    tbl[4]  = '{D_W,    8'h00, 1'b0, 1'b0, S0_BLK,   3'd2, 8'd0};
    tbl[5]  = '{T0_W,   8'hFF, 1'b0, 1'b0, D_BLK,    3'd2, 8'd0};
    tbl[6]  = '{IDLE_W, 8'hFF, 1'b0, 1'b0, T0_BLK,   3'd3, 8'd0};
    tbl[7]  = '{IDLE_W, 8'hFF, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd0};
    tbl[8]  = '{D_W,    8'h00, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd0};
    tbl[9]  = '{IDLE_W, 8'hFF, 1'b0, 1'b0, EBLK,     3'd4, 8'd1};
    tbl[10] = '{IDLE_W, 8'hFF, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd1};
    tbl[11] = '{BYP_W,  8'h00, 1'b1, 1'b0, IDLE_BLK, 3'd1, 8'd1};
    tbl[12] = '{BYP_W,  8'h00, 1'b1, 1'b0, BYP_BLK,  3'd0, 8'd1};
    tbl[13] = '{IDLE_W, 8'hFF, 1'b0, 1'b0, BYP_BLK,  3'd0, 8'd1};
    tbl[14] = '{IDLE_W, 8'hFF, 1'b0, 1'b0, IDLE_BLK, 3'd1, 8'd1};
    tbl[15] = '{IDLE_W, 8'hFF, 1'b0, 1'b1, IDLE_BLK, 3'd1, 8'd0};

    repeat (2) @(posedge clk156);
    @(negedge clk156);
    chk("rst blk", TXD_Encoded, IDLE_BLK);
    chk("rst state", 66'(tx_state), 66'd0);
    chk("rst errd", 66'(errd_blks), 66'd0);
    rstb156 = 1'b1;
    model_reset();

    phase = "table";
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].d, tbl[i].c, 1'b1, tbl[i].byp, tbl[i].clr, 1'b0);
      chk($sformatf("row%0d blk", i), TXD_Encoded, tbl[i].blk);
      chk($sformatf("row%0d state", i), 66'(tx_state), 66'(tbl[i].st));
      chk($sformatf("row%0d errd", i), 66'(errd_blks), 66'(tbl[i].cnt));
    end

    phase = "stall";
    step(S0_W, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    step(D_W, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      gen_word(rd, rc);
      step(rd, rc, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("frozen blk", TXD_Encoded, S0_BLK);
    chk("frozen state", 66'(tx_state), 66'd2);
    step(D_W, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(T0_W, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    step(IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("resume T0", TXD_Encoded, T0_BLK);
    step(IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

    phase = "sat";
    for (int i = 0; i < 300; i++) step(E_W, E_C, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("saturated", 66'(errd_blks), 66'hFF);
    step(E_W, E_C, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clear wins", 66'(errd_blks), 66'd0);
    for (int i = 0; i < 3; i++) step(E_W, E_C, 1'b1, 1'b0, 1'b0, 1'b1);
    step(IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear stalled", 66'(errd_blks), 66'd0);
    step(IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    step(IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

    phase = "midrst";
    step(S0_W, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    step(D_W, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(D_W, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    rstb156 = 1'b0;
    #2;
    chk("async blk", TXD_Encoded, IDLE_BLK);
    chk("async state", 66'(tx_state), 66'd0);
    chk("async errd", 66'(errd_blks), 66'd0);
    @(negedge clk156);
    rstb156 = 1'b1;
    model_reset();
    step(D_W, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    step(IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("first D eblk", TXD_Encoded, EBLK);
    chk("first D state", 66'(tx_state), 66'd4);

    phase = "rand";
    for (int i = 0; i < 400; i++) begin
      gen_word(rd, rc);
      step(rd, rc, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 29) == 0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encode_tx_66b.md
Name: encode_tx_66b

Overview:
- Transmit-side 64b/66b encoder for the 10GBASE-R PCS lane; it is the inverse of the receive decoder.
- Accepts XGMII-style 64-bit data with 8 per-lane control bits and classifies each word.
- Runs the IEEE 49.2.13 transmit state machine and emits one 66-bit block per enabled cycle to the scrambler.
- Counts generated error blocks.

Parameters:
- IDLE_CHAR, 8'h07, XGMII idle character.
- ERR_CHAR, 8'hFE, XGMII error character.

Ports:
- clk156  in  1  156.25 MHz clock.
- rstb156  in  1  asynchronous active-low reset.
- txdata  in  64  XGMII data; lane k = txdata[8k+7:8k].
- txcontrol  in  8  bit k=1 marks lane k as a control character.
- tx_en  in  1  advance enable from the gearbox; 0 = stall.
- bypass_66encoder  in  1  1 = pass data through unencoded.
- clear_errblk  in  1  synchronous clear of the error counter.
- TXD_Encoded  out  66  encoded block; [1:0] sync header, [65:2] payload.
- tx_state  out  3  FSM state, for debug.
- errd_blks  out  8  saturating count of E-blocks emitted.

Behaviour:
- Reset (async assert, sync release):
  - TXD_Encoded = 66'h79 (idle block: header 01, type 0x1E, codes 0).
  - FSM = TX_INIT, errd_blks = 0, pipeline = idle block.
- Sync header: data = 2'b10, control = 2'b01.
- Payload layout:
  - Block type occupies [9:2].
  - The 7-bit control code for lane k occupies [16+7k:10+7k].
  - Codes: /I/ = 7'h00, /E/ = 7'h1E.
- Pipeline: stage 1 registers the T_TYPE classification and the prebuilt block; stage 2 is the FSM and output register. Latency is exactly 2 enabled cycles.
- When tx_en=0, every register (stages, FSM, counter, output) holds its value.
- Classification by control bits c and lane bytes:
  - D: c=8'h00. Payload = txdata.
  - C: c=8'hFF and every lane is 0x07 or 0xFE. Type 0x1E, per-lane codes.
  - C, ordered set: c=8'h01, byte0=0x9C. Type 0x4B; bytes1-3 at [33:10]; [65:34]=0.
  - S0: c=8'h01, byte0=0xFB. Type 0x78; txdata[63:8] at [65:10].
  - S4: c=8'h1F, bytes0-3=0x07, byte4=0xFB. Type 0x33; [41:10]=0; txdata[63:40] at [65:42].
  - T_k (k=0..7): lane k=0xFD; c bits k..7 set and bits below k clear; lanes above k are 0x07.
    - Types for k=0..7: 87,99,AA,B4,CC,D2,E1,FF.
    - Data lanes 0..k-1 at [10+8j +: 8]; remaining payload bits 0.
  - E: anything else, including /E/ or non-idle after /T/, or /S/ in other lanes.
- FSM states and transitions, taken on each enabled cycle:
  - TX_INIT: C→TX_C; S→TX_D; else TX_E.
  - TX_C: C→TX_C; S→TX_D; else TX_E.
  - TX_D: D→TX_D; T→TX_T; else TX_E.
  - TX_T: C→TX_C; S→TX_D; else TX_E.
  - TX_E: C→TX_C; D→TX_D; T→TX_T; S or E→TX_E.
- Output: on a transition into TX_E, emit EBLOCK_T = header 01, type 0x1E, all eight codes 7'h1E. Otherwise emit the stage-1 block.
- tx_state encoding: INIT=0, C=1, D=2, T=3, E=4.
- errd_blks:
  - +1 per emitted EBLOCK_T while tx_en=1; saturates at 8'hFF.
  - clear_errblk has priority over a same-cycle increment.
  - clear_errblk acts even when tx_en=0.
- Bypass: bypass_66encoder=1 forces output {txdata, 2'b10} with the same 2-cycle latency. The FSM is held in TX_INIT and the counter holds.
- Reset asserted mid-packet returns all outputs to their reset values immediately. After release, the first D word must produce EBLOCK_T (INIT→E).

Test Plan:
- Reset, then 4 cycles of c=FF with all lanes 0x07 → TXD_Encoded=66'h79 from the 2nd enabled cycle; tx_state=1.
- Idle, S0 (txdata=64'h5555_5555_5555_55FB, c=01), D 64'h0123456789ABCDEF, T0 (c=FF, byte0=FD, rest 07) → blocks 0x78/payload 55..55 hdr01, then {64'h0123456789ABCDEF,2'b10}, then type 0x87 rest 0; states D,D,T; errd_blks=0.
- D word directly after idle → EBLOCK_T (type 1E, all codes 1E), errd_blks=1. A following C word → idle block, state C.
- Hold tx_en=0 for 3 cycles mid-packet with changing inputs → output, state and counter frozen; resuming gives the correct 2-enabled-cycle latency.
- Drive 300 consecutive E words → errd_blks saturates at FF. Assert clear_errblk together with an E word → errd_blks=0.
- Set bypass_66encoder=1 with txdata=64'hDEADBEEF_00000000 → 2 cycles later TXD_Encoded={64'hDEADBEEF_00000000,2'b10}, tx_state=0.
